mem_data_responder: RTL and testbench

//  Memory-side responder for the core data-memory port: accepts DATA_REQ/ORDER/MASK/RW/ADDR/DATA

---
 rtl/mem_data_responder.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_data_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_data_responder.sv
// mem_data_responder: in-order request FIFO in front of a 64-bit line RAM, answering reads with line pulses.
// Optional out-of-range detection and sticky oERR flag are built when MEM_RESP_RANGE_CHECK_EN is defined.

// Generic synchronous FIFO; registered count, storage not reset.
// Latency: an entry pushed at edge N is visible at pop_dat_o after edge N.
// Backpressure: push ignored while full_o; pop only when pop_vld_o && pop_rdy_i.
module mem_resp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_rdy_i,
    output logic             pop_vld_o,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      cnt_q;
    logic [PW:0]      cnt_d;
    logic             push_fire;
    logic             pop_fire;

    assign full_o    = (cnt_q == (PW+1)'(DEPTH));
    assign pop_vld_o = (cnt_q != '0);
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign push_fire = push_vld_i && !full_o;
    assign pop_fire  = pop_rdy_i && pop_vld_o;

    always_comb begin
        cnt_d = cnt_q;
        if (push_fire && !pop_fire) begin
            cnt_d = cnt_q + (PW+1)'(1);
        end else if (!push_fire && pop_fire) begin
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push_fire) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_fire)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_fire) mem_q[wr_ptr_q] <= push_dat_i;
    end
endmodule

// Data-memory responder: queue requests, apply writes / read lines in order, return reads as pulses.
// Latency: accept edge T, pop edge T+1, oDATA_VALID after edge T+1+READ_LAT.
// Backpressure: oDATA_LOCK while the request FIFO is full; responses cannot be stalled.
module mem_data_responder #(
    parameter int ADDR_W     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int READ_LAT   = 2
) (
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iDATA_REQ,
    output logic        oDATA_LOCK,
    input  logic [1:0]  iDATA_ORDER,
    input  logic [3:0]  iDATA_MASK,
    input  logic        iDATA_RW,
    input  logic [31:0] iDATA_ADDR,
    input  logic [31:0] iDATA_DATA,
    output logic        oDATA_VALID,
    output logic [63:0] oDATA_DATA
`ifdef MEM_RESP_RANGE_CHECK_EN
    ,
    output logic        oERR
`endif
);
    localparam logic [63:0] BAD_DAT = 64'hDEAD_BEEF_DEAD_BEEF;

    // Request pre-decoded at push so the FIFO carries only what the pop side needs.
    typedef struct packed {
        logic              none;
        logic              rw;
        logic              oor;
        logic              half;
        logic [ADDR_W-1:0] line;
        logic [3:0]        mask;
        logic [31:0]       data;
    } entry_t;

    entry_t      push_ent;
    entry_t      head;
    logic        head_vld;
    logic        wr_fire;
    logic        rd_fire;
    logic        unused_addr;

    logic [63:0] mem_q [2**ADDR_W];
    logic [63:0] rd_raw_q;
    logic        rd_oor_q;
    logic        rd_vld_q;
    logic [63:0] s0_dat;
    logic        tail_vld;
    logic [63:0] tail_dat;
    logic        valid_q;
    logic [63:0] data_q;

    always_comb begin
        push_ent      = '0;
        push_ent.none = (iDATA_ORDER == 2'b11);
        push_ent.rw   = iDATA_RW;
        push_ent.half = iDATA_ADDR[2];
        push_ent.line = iDATA_ADDR[ADDR_W+2:3];
        push_ent.mask = iDATA_MASK;
        push_ent.data = iDATA_DATA;
`ifdef MEM_RESP_RANGE_CHECK_EN
        push_ent.oor  = |iDATA_ADDR[31:ADDR_W+3];
`else
        push_ent.oor  = 1'b0;
`endif
    end

`ifdef MEM_RESP_RANGE_CHECK_EN
    assign unused_addr = ^iDATA_ADDR[1:0];
`else
    assign unused_addr = ^{iDATA_ADDR[31:ADDR_W+3], iDATA_ADDR[1:0]};
`endif

    mem_resp_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk_i      (iCLOCK),
        .rst_i      (iRESET_SYNC),
        .push_vld_i (iDATA_REQ),
        .push_dat_i (push_ent),
        .pop_rdy_i  (1'b1),
        .pop_vld_o  (head_vld),
        .pop_dat_o  (head),
        .full_o     (oDATA_LOCK)
    );

    // The head is popped every cycle it is valid; dropped entries simply fall through.
    assign wr_fire = head_vld && !head.none && head.rw && !head.oor;
    assign rd_fire = head_vld && !head.none && !head.rw;

    always_ff @(posedge iCLOCK) begin
        if (wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (head.mask[b]) begin
                    mem_q[head.line][{head.half, 2'(b), 3'b000} +: 8] <= head.data[8*b +: 8];
                end
            end
        end
        rd_raw_q <= mem_q[head.line];
        rd_oor_q <= head.oor;
    end

    assign s0_dat = rd_oor_q ? BAD_DAT : rd_raw_q;

    generate
        if (READ_LAT == 1) begin : g_nodly
            assign tail_vld = rd_vld_q;
            assign tail_dat = s0_dat;
        end else begin : g_dly
            logic [READ_LAT-2:0] dly_vld_q;
            logic [63:0]         dly_dat_q [READ_LAT-1];

            always_ff @(posedge iCLOCK) begin
                if (iRESET_SYNC) begin
                    dly_vld_q <= '0;
                end else begin
                    dly_vld_q[0] <= rd_vld_q;
                    for (int k = 1; k < READ_LAT-1; k++) begin
                        dly_vld_q[k] <= dly_vld_q[k-1];
                    end
                end
            end

            always_ff @(posedge iCLOCK) begin
                dly_dat_q[0] <= s0_dat;
                for (int k = 1; k < READ_LAT-1; k++) begin
                    dly_dat_q[k] <= dly_dat_q[k-1];
                end
            end

            assign tail_vld = dly_vld_q[READ_LAT-2];
            assign tail_dat = dly_dat_q[READ_LAT-2];
        end
    endgenerate

    // Output data only moves on a response so it holds the last read between pulses.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            rd_vld_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            rd_vld_q <= rd_fire;
            valid_q  <= tail_vld;
            if (tail_vld) data_q <= tail_dat;
        end
    end

    assign oDATA_VALID = valid_q;
    assign oDATA_DATA  = data_q;

`ifdef MEM_RESP_RANGE_CHECK_EN
    logic err_q;

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            err_q <= 1'b0;
        end else if (head_vld && !head.none && head.oor) begin
            err_q <= 1'b1;
        end
    end

    assign oERR = err_q;
`endif
endmodule

// File: tb/tb_mem_data_responder.sv
// Bench for mem_data_responder: transaction-level queue model checked every cycle, plus directed literal cases.
module tb_mem_data_responder;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 4;
    localparam int LAT    = 2;
    localparam int NLINES = 32;
`ifdef MEM_RESP_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        iCLOCK = 1'b0;
    logic        iRESET_SYNC = 1'b1;
    logic        iDATA_REQ = 1'b0;
    logic [1:0]  iDATA_ORDER = 2'b00;
    logic [3:0]  iDATA_MASK = 4'h0;
    logic        iDATA_RW = 1'b0;
    logic [31:0] iDATA_ADDR = 32'h0;
    logic [31:0] iDATA_DATA = 32'h0;
    logic        oDATA_LOCK;
    logic        oDATA_VALID;
    logic [63:0] oDATA_DATA;
`ifdef MEM_RESP_RANGE_CHECK_EN
    logic        oERR;
`endif

    always #5 iCLOCK = ~iCLOCK;

    mem_data_responder #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (DEPTH),
        .READ_LAT   (LAT)
    ) dut (
        .iCLOCK      (iCLOCK),
        .iRESET_SYNC (iRESET_SYNC),
        .iDATA_REQ   (iDATA_REQ),
        .oDATA_LOCK  (oDATA_LOCK),
        .iDATA_ORDER (iDATA_ORDER),
        .iDATA_MASK  (iDATA_MASK),
        .iDATA_RW    (iDATA_RW),
        .iDATA_ADDR  (iDATA_ADDR),
        .iDATA_DATA  (iDATA_DATA),
        .oDATA_VALID (oDATA_VALID),
        .oDATA_DATA  (oDATA_DATA)
`ifdef MEM_RESP_RANGE_CHECK_EN
        ,
        .oERR        (oERR)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at time %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of accepted requests, queue of scheduled responses with due cycle.
    typedef struct {
        logic        rw;
        logic [1:0]  order;
        logic [3:0]  mask;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;
    typedef struct {
        int          due;
        logic [63:0] d;
    } rsp_t;

    req_t        fq[$];
    rsp_t        rq[$];
    logic [63:0] mm [2**ADDR_W];
    int          cyc = 0;
    logic        m_vld = 1'b0;
    logic        m_lock = 1'b0;
    logic        m_err = 1'b0;
    logic [63:0] m_dat = '0;
    req_t        m_e;
    req_t        m_in;
    rsp_t        m_r;
    bit          m_lk;
    bit          m_oor;
    int          m_ln;
    int          m_base;

    always @(posedge iCLOCK) begin
        cyc++;
        m_vld = 1'b0;
        if (iRESET_SYNC) begin
            fq.delete();
            rq.delete();
            m_dat = '0;
            m_err = 1'b0;
        end else begin
            m_lk = (fq.size() == DEPTH);
            if (fq.size() > 0) begin
                m_e = fq.pop_front();
                if (m_e.order != 2'b11) begin
                    m_ln  = int'(m_e.addr[ADDR_W+2:3]);
                    m_oor = RC && (m_e.addr[31:ADDR_W+3] != '0);
                    if (m_oor) m_err = 1'b1;
                    if (m_e.rw) begin
                        if (!m_oor) begin
                            for (int b = 0; b < 4; b++) begin
                                m_base = (m_e.addr[2] ? 32 : 0) + 8 * b;
                                if (m_e.mask[b]) mm[m_ln][m_base +: 8] = m_e.data[8*b +: 8];
                            end
                        end
                    end else begin
                        m_r.due = cyc + LAT;
                        m_r.d   = m_oor ? 64'hDEAD_BEEF_DEAD_BEEF : mm[m_ln];
                        rq.push_back(m_r);
                    end
                end
            end
            if (iDATA_REQ && !m_lk) begin
                m_in.rw    = iDATA_RW;
                m_in.order = iDATA_ORDER;
                m_in.mask  = iDATA_MASK;
                m_in.addr  = iDATA_ADDR;
                m_in.data  = iDATA_DATA;
                fq.push_back(m_in);
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                m_vld = 1'b1;
                m_dat = rq[0].d;
                void'(rq.pop_front());
            end
        end
        m_lock = (fq.size() == DEPTH);
    end

    always @(negedge iCLOCK) begin
        if (chk_en) begin
            chk("lock", {63'b0, oDATA_LOCK}, {63'b0, m_lock});
            chk("valid", {63'b0, oDATA_VALID}, {63'b0, m_vld});
            chk("data", oDATA_DATA, m_dat);
`ifdef MEM_RESP_RANGE_CHECK_EN
            chk("err", {63'b0, oERR}, {63'b0, m_err});
`endif
        end
    end

    // Pulse bookkeeping for the directed cases.
    int ncyc = 0;
    int vcount = 0;
    int vfirst = -1;
    int vlast = -1;

    always @(negedge iCLOCK) begin
        ncyc++;
        if (oDATA_VALID) begin
            if (vfirst < 0) vfirst = ncyc;
            vlast = ncyc;
            vcount++;
        end
    end

    task automatic clr_pulses();
        vcount = 0;
        vfirst = -1;
        vlast  = -1;
    endtask

    task automatic send(input logic rw, input logic [1:0] ord, input logic [3:0] mask,
                        input logic [31:0] addr, input logic [31:0] data);
        logic lk;
        int   n;
        n = 0;
        iDATA_REQ   = 1'b1;
        iDATA_RW    = rw;
        iDATA_ORDER = ord;
        iDATA_MASK  = mask;
        iDATA_ADDR  = addr;
        iDATA_DATA  = data;
        do begin
            lk = oDATA_LOCK;
            @(posedge iCLOCK);
            @(negedge iCLOCK);
            n++;
        end while (lk && n < 50);
        chk("accept", {63'b0, lk}, 64'd0);
        iDATA_REQ = 1'b0;
    endtask

    task automatic idle(input int n);
        iDATA_REQ = 1'b0;
        repeat (n) @(negedge iCLOCK);
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        do begin
            @(negedge iCLOCK);
            k++;
        end while (!oDATA_VALID && k < 20);
        chk("valid_seen", {63'b0, oDATA_VALID}, 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        logic [31:0] a;

        repeat (3) @(negedge iCLOCK);
        chk("rst_valid", {63'b0, oDATA_VALID}, 64'd0);
        chk("rst_lock", {63'b0, oDATA_LOCK}, 64'd0);
        chk("rst_data", oDATA_DATA, 64'd0);
        iRESET_SYNC = 1'b0;
        chk_en = 1'b1;

        for (int l = 0; l < NLINES; l++) begin
            send(1'b1, 2'b10, 4'hF, 32'(l * 8), $urandom);
            send(1'b1, 2'b10, 4'hF, 32'(l * 8 + 4), $urandom);
        end
        idle(4);

        // Full-word write then read of the lower half; latency counted from the read accept edge.
        send(1'b1, 2'b10, 4'hF, 32'h10, 32'h1122_3344);
        send(1'b0, 2'b10, 4'hF, 32'h10, 32'h0);
        wait_valid(k);
        chk("t1_latency", 64'(k), 64'd3);
        chk("t1_lower", {32'b0, oDATA_DATA[31:0]}, 64'h1122_3344);
        idle(3);

        send(1'b1, 2'b10, 4'hF, 32'h14, 32'h1122_3344);
        send(1'b1, 2'b00, 4'b0100, 32'h14, 32'h00AA_0000);
        send(1'b0, 2'b10, 4'hF, 32'h10, 32'h0);
        wait_valid(k);
        chk("t2_upper", {32'b0, oDATA_DATA[63:32]}, 64'h11AA_3344);
        chk("t2_lower", {32'b0, oDATA_DATA[31:0]}, 64'h1122_3344);
        idle(3);

        clr_pulses();
        for (int i = 0; i < 8; i++) send(1'b0, 2'b10, 4'hF, 32'(i * 8), 32'h0);
        idle(10);
        chk("t3_count", 64'(vcount), 64'd8);
        chk("t3_span", 64'(vlast - vfirst + 1), 64'd8);

        clr_pulses();
        send(1'b0, 2'b10, 4'hF, 32'h20, 32'h0);
        send(1'b0, 2'b11, 4'hF, 32'h28, 32'h0);
        send(1'b0, 2'b10, 4'hF, 32'h30, 32'h0);
        idle(10);
        chk("t4_count", 64'(vcount), 64'd2);

        // Reset with three reads queued / in flight: nothing may come out afterwards.
        send(1'b0, 2'b10, 4'hF, 32'h10, 32'h0);
        send(1'b0, 2'b10, 4'hF, 32'h18, 32'h0);
        send(1'b0, 2'b10, 4'hF, 32'h20, 32'h0);
        clr_pulses();
        iRESET_SYNC = 1'b1;
        idle(2);
        iRESET_SYNC = 1'b0;
        idle(10);
        chk("t5_no_pulse", 64'(vcount), 64'd0);
        chk("t5_lock", {63'b0, oDATA_LOCK}, 64'd0);
        chk("t5_data", oDATA_DATA, 64'd0);
        send(1'b0, 2'b10, 4'hF, 32'h10, 32'h0);
        wait_valid(k);
        chk("t5_latency", 64'(k), 64'd3);
        chk("t5_ram_kept", oDATA_DATA, 64'h11AA_3344_1122_3344);
        idle(3);

        send(1'b1, 2'b10, 4'hF, 32'h0, 32'h89AB_CDEF);
        send(1'b1, 2'b10, 4'hF, 32'h4, 32'h0123_4567);
        send(1'b0, 2'b10, 4'hF, 32'h0001_0000, 32'h0);
        wait_valid(k);
`ifdef MEM_RESP_RANGE_CHECK_EN
        chk("t6_oor_read", oDATA_DATA, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("t6_err", {63'b0, oERR}, 64'd1);
`else
        chk("t6_wrap_read", oDATA_DATA, 64'h0123_4567_89AB_CDEF);
`endif
        send(1'b1, 2'b10, 4'hF, 32'h0001_0000, 32'hFFFF_FFFF);
        send(1'b0, 2'b10, 4'hF, 32'h0, 32'h0);
        wait_valid(k);
`ifdef MEM_RESP_RANGE_CHECK_EN
        chk("t6_line0_kept", oDATA_DATA, 64'h0123_4567_89AB_CDEF);
`else
        chk("t6_line0_wrapped", oDATA_DATA, 64'h0123_4567_FFFF_FFFF);
`endif
        idle(3);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                a = $urandom;
                a[12:3] = 10'($urandom_range(0, NLINES - 1));
                if ($urandom_range(0, 4) != 0) a[31:13] = '0;
                send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                     a, $urandom);
            end
        end
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
